// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: vertical state encoding, default vertical
// timing constants and a helper that sums the line counts of one frame.
package vga_timing_pkg;

  typedef enum logic [1:0] {ACT, FP, SYNC, BP} vstate_e;

  localparam int unsigned VActiveDef = 480;
  localparam int unsigned VFrontDef  = 10;
  localparam int unsigned VSyncDef   = 2;
  localparam int unsigned VBackDef   = 33;
  localparam int unsigned LineWDef   = 10;

  function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous input value and pulses rise_o
// for the cycle in which the input is high and the registered copy is low.
// ResetVal sets the registered copy at reset, so an input already high at
// reset release can be kept from counting as an edge.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   sig_i  - monitored signal
//   rise_o - combinational rising-edge pulse
module rise_detect #(
  parameter bit ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= ResetVal;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/vsync.sv
// Vertical timing generator. Counts one line per rising edge of i_hblank and
// derives vertical sync, vertical blank, the line index, a frame-start pulse
// and the display enable.
//   i_clk         - pixel clock
//   i_rst         - asynchronous active-high reset
//   i_hblank      - horizontal blank; rising edge ends a line
//   o_vsync       - vertical sync, active-low
//   o_vblank      - high outside the active lines
//   o_line        - current line index, 0..V_TOTAL-1
//   o_frame_start - one-cycle pulse after the line wraps to 0
//   o_de          - display enable, ~i_hblank & ~o_vblank
module vsync
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned V_FRONT  = VFrontDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BACK   = VBackDef,
  parameter int unsigned LINE_W   = LineWDef
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hblank,
  output logic              o_vsync,
  output logic              o_vblank,
  output logic [LINE_W-1:0] o_line,
  output logic              o_frame_start,
  output logic              o_de
);

  localparam int unsigned VTotal = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [LINE_W-1:0] LastLine  = LINE_W'(VTotal - 1);
  localparam logic [LINE_W-1:0] FpStart   = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] SyncStart = LINE_W'(V_ACTIVE + V_FRONT);
  localparam logic [LINE_W-1:0] BpStart   = LINE_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic              line_end;
  logic [LINE_W-1:0] line_q, line_d;
  vstate_e           state_q, state_d;
  logic              fs_q, fs_d;

  // Reset value 1: an i_hblank already high at reset release is not an edge.
  rise_detect #(
    .ResetVal(1'b1)
  ) u_rise (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .sig_i (i_hblank),
    .rise_o(line_end)
  );

  // State follows from the next line value; no per-state sub-counter.
  always_comb begin
    line_d  = line_q;
    state_d = state_q;
    fs_d    = 1'b0;
    if (line_end) begin
      if (line_q == LastLine) begin
        line_d = '0;
        fs_d   = 1'b1;
      end else begin
        line_d = line_q + 1'b1;
      end
      if (line_d < FpStart) begin
        state_d = ACT;
      end else if (line_d < SyncStart) begin
        state_d = FP;
      end else if (line_d < BpStart) begin
        state_d = SYNC;
      end else begin
        state_d = BP;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      line_q  <= '0;
      state_q <= ACT;
      fs_q    <= 1'b0;
    end else begin
      line_q  <= line_d;
      state_q <= state_d;
      fs_q    <= fs_d;
    end
  end

  assign o_line        = line_q;
  assign o_vblank      = (state_q != ACT);
  assign o_vsync       = ~(state_q == SYNC);
  assign o_frame_start = fs_q;
  assign o_de          = ~i_hblank & ~o_vblank;

  // Configuration sanity: every segment must be at least one line and the
  // counter must be wide enough to hold the last line index.
  always_ff @(posedge i_clk) begin
    assert (V_ACTIVE >= 1 && V_FRONT >= 1 && V_SYNC >= 1 && V_BACK >= 1)
      else $error("vsync: timing parameters must each be >= 1");
    assert (LINE_W < 32 && (64'd1 << LINE_W) >= 64'(VTotal))
      else $error("vsync: LINE_W too narrow for V_TOTAL");
  end

endmodule

// File: tb/tb_vsync.sv
module tb_vsync;

  localparam int SA = 4, SF = 1, SS = 2, SB = 1, ST = 8;
  localparam int DA = 480, DF = 10, DS = 2, DB = 33, DT = 525;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hb  = 1'b0;

  logic       s_vsync, s_vblank, s_fs, s_de;
  logic [2:0] s_line;
  logic       d_vsync, d_vblank, d_fs, d_de;
  logic [9:0] d_line;

  int vec = 0;
  int err = 0;

  vsync #(
    .V_ACTIVE(SA), .V_FRONT(SF), .V_SYNC(SS), .V_BACK(SB), .LINE_W(3)
  ) dut_s (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hblank     (hb),
    .o_vsync      (s_vsync),
    .o_vblank     (s_vblank),
    .o_line       (s_line),
    .o_frame_start(s_fs),
    .o_de         (s_de)
  );

  vsync dut_d (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hblank     (hb),
    .o_vsync      (d_vsync),
    .o_vblank     (d_vblank),
    .o_line       (d_line),
    .o_frame_start(d_fs),
    .o_de         (d_de)
  );

  always #5 clk = ~clk;

  // Reference: count of line ends since reset; every output is a function of it.
  int m_cnt;
  bit m_prev;
  bit m_edge;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_prev <= 1'b1;
      m_edge <= 1'b0;
    end else begin
      m_prev <= hb;
      m_edge <= hb & ~m_prev;
      if (hb && !m_prev) m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int exp_vsync(input int line, input int a, input int f, input int s);
    return (line >= a + f && line < a + f + s) ? 0 : 1;
  endfunction

  int s_fs_cnt = 0;
  int d_fs_cnt = 0;
  int d_fs_at[$];
  int d_max = 0;

  always @(negedge clk) begin
    int sl, dl;
    sl = m_cnt % ST;
    dl = m_cnt % DT;
    check("s_line",   int'(s_line), sl);
    check("s_vblank", int'(s_vblank), (sl >= SA) ? 1 : 0);
    check("s_vsync",  int'(s_vsync), exp_vsync(sl, SA, SF, SS));
    check("s_fs",     int'(s_fs), (m_edge && sl == 0) ? 1 : 0);
    check("s_de",     int'(s_de), (!hb && sl < SA) ? 1 : 0);
    check("d_line",   int'(d_line), dl);
    check("d_vblank", int'(d_vblank), (dl >= DA) ? 1 : 0);
    check("d_vsync",  int'(d_vsync), exp_vsync(dl, DA, DF, DS));
    check("d_fs",     int'(d_fs), (m_edge && dl == 0) ? 1 : 0);
    check("d_de",     int'(d_de), (!hb && dl < DA) ? 1 : 0);
    if (s_fs === 1'b1) s_fs_cnt++;
    if (d_fs === 1'b1) begin
      d_fs_cnt++;
      d_fs_at.push_back(m_cnt);
    end
    if (int'(d_line) > d_max) d_max = int'(d_line);
  end

  task automatic pulse(input int lo, input int hi);
    repeat (lo) begin @(posedge clk); #1 hb = 1'b0; end
    repeat (hi) begin @(posedge clk); #1 hb = 1'b1; end
  endtask

  task automatic do_reset(input logic hb_val);
    @(posedge clk); #1;
    rst = 1'b1;
    hb  = hb_val;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int exp_line[8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
  int exp_vb[8]    = '{0, 0, 0, 1, 1, 1, 1, 0};
  int exp_vs[8]    = '{1, 1, 1, 1, 0, 0, 1, 1};
  int exp_fs[8]    = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with hblank low: outputs hold reset values.
    repeat (20) @(posedge clk);
    #1;
    check("idle_line", int'(s_line), 0);
    check("idle_vsync", int'(s_vsync), 1);
    check("idle_vblank", int'(s_vblank), 0);
    check("idle_fs", int'(s_fs), 0);

    // One full small frame.
    s_fs_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      pulse(3, 2);
      check("frame_line", int'(s_line), exp_line[k]);
      check("frame_vblank", int'(s_vblank), exp_vb[k]);
      check("frame_vsync", int'(s_vsync), exp_vs[k]);
      check("frame_fs", int'(s_fs), exp_fs[k]);
    end
    repeat (3) @(posedge clk);
    check("frame_fs_count", s_fs_cnt, 1);

    // hblank held high across reset release.
    do_reset(1'b1);
    repeat (4) @(posedge clk);
    #1 check("hb_high_line", int'(s_line), 0);
    hb = 1'b0;
    @(posedge clk); #1 hb = 1'b1;
    @(posedge clk); #1 check("hb_high_first", int'(s_line), 1);

    // Reset in the middle of SYNC.
    do_reset(1'b0);
    repeat (5) pulse(3, 2);
    check("pre_rst_vsync", int'(s_vsync), 0);
    check("pre_rst_line", int'(s_line), 5);
    s_fs_cnt = 0;
    #2 rst = 1'b1;
    #1;
    check("async_vsync", int'(s_vsync), 1);
    check("async_line", int'(s_line), 0);
    check("async_vblank", int'(s_vblank), 0);
    @(posedge clk); #1 rst = 1'b0;
    hb = 1'b0;
    pulse(3, 2);
    check("post_rst_line", int'(s_line), 1);
    check("post_rst_fs", s_fs_cnt, 0);

    // Random hblank activity; the per-cycle compare covers o_de and all state.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1 hb = 1'($urandom_range(0, 1));
    end

    // Default timing: 1050 line ends from reset.
    do_reset(1'b0);
    d_fs_cnt = 0;
    d_fs_at.delete();
    d_max = 0;
    repeat (1050) pulse(1, 1);
    repeat (4) @(posedge clk);
    #1;
    check("dflt_fs_count", d_fs_cnt, 2);
    if (d_fs_at.size() == 2) begin
      check("dflt_fs_first", d_fs_at[0], 525);
      check("dflt_fs_spacing", d_fs_at[1] - d_fs_at[0], 525);
    end
    check("dflt_max_line", d_max, 524);

    // Stuck-high hblank freezes everything.
    repeat (20) @(posedge clk);
    #1 check("stuck_line", int'(d_line), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/vsync.md
# vsync

Vertical timing generator for the VGA output path, directly downstream of the horizontal sync stage. It consumes that stage's `i_hblank` and counts one line per rising edge. From the line count it produces the vertical sync, vertical blank, current line index, a one-cycle frame-start pulse and the combined display-enable. The pixel fetch logic and the output pins consume these outputs.

## Interface
Parameters:
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, front-porch lines
- `V_SYNC`, 2, sync-pulse lines
- `V_BACK`, 33, back-porch lines
- `LINE_W`, 10, width of `o_line`; must satisfy 2^LINE_W ≥ V_ACTIVE+V_FRONT+V_SYNC+V_BACK

Ports:
- `i_clk` in 1: pixel clock, shared with the horizontal sync stage
- `i_rst` in 1: reset, asynchronous, active-high
- `i_hblank` in 1: horizontal blank from the horizontal sync stage; its rising edge marks end of line
- `o_vsync` out 1: vertical sync, active-low
- `o_vblank` out 1: high outside the active lines
- `o_line` out LINE_W: current line index, 0..V_TOTAL-1
- `o_frame_start` out 1: one-cycle pulse when `o_line` wraps to 0
- `o_de` out 1: display enable, `~i_hblank & ~o_vblank` (combinational)

## Operation
- The block registers `hb_q <= i_hblank` on every clock. `line_end = i_hblank & ~hb_q`.
- `V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK`.
- State machine, advanced only on `line_end`:
  - `ACT` (lines 0..V_ACTIVE-1) → `FP` at line V_ACTIVE
  - `FP` → `SYNC` at V_ACTIVE+V_FRONT
  - `SYNC` → `BP` at V_ACTIVE+V_FRONT+V_SYNC
  - `BP` → `ACT` at wrap to 0
- The state is selected by comparing the next line value against the boundaries. No per-state sub-counter is used.
- Line counter: on `line_end`, if `o_line == V_TOTAL-1` it becomes 0, otherwise it becomes `o_line+1`. The increment is unsigned at LINE_W bits and never exceeds V_TOTAL-1.
- Registered outputs:
  - `o_vblank = (state != ACT)`
  - `o_vsync = ~(state == SYNC)`
  - `o_frame_start = 1` for exactly the cycle after the edge that wrapped the line to 0, otherwise 0
- Between line ends, all registered outputs hold their values.
- Reset values: `o_line=0`, state `ACT`, `o_vsync=1`, `o_vblank=0`, `o_frame_start=0`, `hb_q=1`.
  - `hb_q=1` ensures that an `i_hblank` already high at reset release is not counted as an edge.
- Reset mid-frame: the block abandons the frame immediately and asynchronously. After release, the first counted edge advances the line to 1. No `o_frame_start` pulse is generated for the reset itself.
- A constant `i_hblank` (stuck 0 or 1) produces no `line_end`, so all outputs freeze.
- Parameters must each be ≥1. A value of 0 is a configuration error, flagged by a simulation-only assertion.

## Timing
- Latency: the rising edge of `i_hblank` is sampled at clock edge N, and `o_line`, `o_vblank`, `o_vsync` and `o_frame_start` change after edge N. This is one cycle after `i_hblank` is first seen high.
- `o_de` has zero latency with respect to `i_hblank`. It uses the registered `o_vblank`.
- A line end needs `i_hblank` low for ≥1 cycle, then high. Back-to-back lines need ≥2 cycles per line.
- `o_vsync` stays low for exactly V_SYNC lines. It falls and rises coincident with the corresponding line-end updates.

## Structure
- Shared package `vga_timing_pkg`:
  - state enum `{ACT, FP, SYNC, BP}`
  - default vertical timing constants
  - `V_TOTAL` function
- Sub-module `rise_detect`: registered previous value with configurable reset value, outputting the `line_end` pulse. It is reusable by other VGA stages.
- The remaining logic (counter, state machine, output registers) lives in `vsync`. The expected size is about 150 lines.

## Test plan
Use V_ACTIVE=4, V_FRONT=1, V_SYNC=2, V_BACK=1 (V_TOTAL=8) unless stated otherwise.
- Reset then idle with `i_hblank=0` → `o_line=0`, `o_vsync=1`, `o_vblank=0`, `o_frame_start=0` held indefinitely.
- 8 `i_hblank` pulses (3 cycles low, 2 high) → `o_line` steps 1,2,…,7,0. `o_vblank` rises on line 4 and falls on 0. `o_vsync` is low on lines 5–6 only. `o_frame_start` is high for 1 cycle at the wrap.
- `i_hblank` held high across reset release → no increment until `i_hblank` goes low, then high. `o_line` becomes 1 one cycle after that edge.
- Assert `i_rst` mid-SYNC (line 5) for 1 cycle → `o_vsync=1`, `o_line=0`, `o_vblank=0` immediately, without waiting for a clock. No `o_frame_start` pulse.
- During ACT lines, toggle `i_hblank` → `o_de == ~i_hblank` in the same cycle. During FP/SYNC/BP, `o_de=0` throughout.
- Default parameters, 1050 line ends → `o_frame_start` fires twice, 525 line ends apart. Maximum `o_line` observed is 524.
